cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter ENTRY_SIZE, default 4, meaning ROB tag width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning per-source holding FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global run enable; low = pause.
REQ-006 SHALL have port roll_back  input  1  misprediction flush.
REQ-007 SHALL have ports rs_valid/lsb_valid  input  1 each  source has a result this cycle.
REQ-008 SHALL have ports rs_entry/lsb_entry  input  ENTRY_SIZE each  ROB tag of the result.
REQ-009 SHALL have ports rs_result/lsb_result  input  32 each  result value.
REQ-010 SHALL have ports rs_ready/lsb_ready  output  1 each  source FIFO can accept.
REQ-011 SHALL have port cdb_valid  output  1  broadcast strobe to ROB/RS/LSB/register file.
REQ-012 SHALL have ports cdb_entry (ENTRY_SIZE), cdb_result (32), cdb_src (1; 0=RS, 1=LSB)  outputs  broadcast payload.

Function
REQ-013 SHALL accept a source item when valid && ready, rdy_in=1, roll_back=0, and rst_in=1.
REQ-014 SHALL drive ready = rdy_in && !roll_back && (FIFO count < FIFO_DEPTH); a same-cycle pop SHALL NOT make a full FIFO ready.
REQ-015 SHALL manage each FIFO with read/write pointers that wrap modulo FIFO_DEPTH and a count of 0..FIFO_DEPTH.
REQ-016 SHALL support same-cycle push and pop on a non-full, non-empty FIFO, leaving the count unchanged.
REQ-017 SHALL grant at most one FIFO head per cycle, pop it, and register it onto cdb_* outputs, valid on the following cycle.
REQ-018 SHALL have a minimum latency of 2 cycles from acceptance to cdb_valid: one cycle to write the FIFO and one to register the grant.
REQ-019 SHALL deassert cdb_valid in any cycle following one with no grant.
REQ-020 SHALL hold cdb_entry/cdb_result/cdb_src at their last values while cdb_valid=0.
REQ-021 SHALL preserve per-source order, with no reordering within a source.
REQ-022 SHALL, when both FIFOs are non-empty, grant per the arbitration policy (REQ-030/031).
REQ-023 SHALL, when only one FIFO is non-empty, grant that FIFO regardless of policy.
REQ-024 SHALL, while rdy_in=0, freeze all state (FIFOs, pointers, arbitration pointer, cdb_* registers) and drive ready outputs low.
REQ-025 SHALL, on roll_back=1 with rdy_in=1, empty both FIFOs and zero their pointers.
REQ-026 SHALL, on roll_back=1 with rdy_in=1, drive cdb_valid=0 the next cycle and drop incoming requests.
REQ-027 SHALL, on roll_back=1 with rdy_in=1, produce no grant that cycle.

Reset
REQ-028 SHALL, when rst_in=0 at a clock edge, empty both FIFOs, zero pointers and counts, and set cdb_valid=0, cdb_entry=0, cdb_result=0, cdb_src=0.
REQ-029 SHALL, when rst_in=0 at a clock edge, set the arbitration pointer to favour RS next; reset SHALL take priority over rdy_in and roll_back, and SHALL abort in-flight items.

Configuration
REQ-030 SHALL, with macro CDB_ARB_ROUND_ROBIN_EN defined, alternate grants when both FIFOs are non-empty: grant the source not granted last, with the pointer updated only on a contended grant.
REQ-031 SHALL, without macro CDB_ARB_ROUND_ROBIN_EN, grant LSB with fixed priority over RS when both FIFOs are non-empty, with the arbitration pointer unused.

Verification
REQ-032 SHALL cover: reset then rs_valid=1, entry=3, result=0x1234 for one cycle -> cdb_valid=1 exactly 2 cycles later with entry=3, result=0x1234, src=0.
REQ-033 SHALL cover: RS and LSB each push one item in the same cycle (entries 1, 2) -> round-robin build broadcasts entry 1 then entry 2 on consecutive cycles; fixed build broadcasts 2 then 1.
REQ-034 SHALL cover: LSB pushes 4 items back-to-back with FIFO_DEPTH=2 and RS idle -> lsb_ready drops while the FIFO is full, and all 4 broadcast in order with no loss.
REQ-035 SHALL cover: both FIFOs full, roll_back pulsed for one cycle -> cdb_valid=0 next cycle, ready high again the cycle after, and no flushed entry ever broadcast.
REQ-036 SHALL cover: rdy_in held low for 3 cycles with items queued and cdb_valid=1 -> outputs and counts unchanged throughout, and draining resumes exactly where it left off.
REQ-037 SHALL cover: rst_in pulled low mid-drain -> next cycle cdb_valid=0, both ready outputs high, and no stale entries later.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle for the common data bus arbiter.
// Sources push results in; the arbiter broadcasts one result per cycle out.
interface cdb_arbiter_if #(
    parameter int ENTRY_SIZE = 4
);
    logic                  rs_valid;
    logic [ENTRY_SIZE-1:0] rs_entry;
    logic [31:0]           rs_result;
    logic                  rs_ready;

    logic                  lsb_valid;
    logic [ENTRY_SIZE-1:0] lsb_entry;
    logic [31:0]           lsb_result;
    logic                  lsb_ready;

    logic                  cdb_valid;
    logic [ENTRY_SIZE-1:0] cdb_entry;
    logic [31:0]           cdb_result;
    logic                  cdb_src;

    modport master (
        output rs_valid, rs_entry, rs_result,
        output lsb_valid, lsb_entry, lsb_result,
        input  rs_ready, lsb_ready,
        input  cdb_valid, cdb_entry, cdb_result, cdb_src
    );

    modport slave (
        input  rs_valid, rs_entry, rs_result,
        input  lsb_valid, lsb_entry, lsb_result,
        output rs_ready, lsb_ready,
        output cdb_valid, cdb_entry, cdb_result, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source FIFOs feeding one registered broadcast.
// Define CDB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed LSB priority.
module cdb_arbiter #(
    parameter int ENTRY_SIZE = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           roll_back,
    cdb_arbiter_if.slave   bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = ENTRY_SIZE + 32;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DW-1:0] r_rs_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rs_wp;
    logic [PW-1:0] r_rs_rp;
    logic [CW-1:0] r_rs_cnt;

    logic [DW-1:0] r_lsb_mem [FIFO_DEPTH];
    logic [PW-1:0] r_lsb_wp;
    logic [PW-1:0] r_lsb_rp;
    logic [CW-1:0] r_lsb_cnt;

    logic                  r_cdb_valid;
    logic [ENTRY_SIZE-1:0] r_cdb_entry;
    logic [31:0]           r_cdb_result;
    logic                  r_cdb_src;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic r_prio_lsb;
`endif

    logic          w_run;
    logic          w_rs_ready;
    logic          w_lsb_ready;
    logic          w_rs_push;
    logic          w_lsb_push;
    logic          w_rs_ne;
    logic          w_lsb_ne;
    logic          w_grant_rs;
    logic          w_grant_lsb;
    logic [DW-1:0] w_rs_head;
    logic [DW-1:0] w_lsb_head;

    assign w_run       = rdy_in & ~roll_back;
    assign w_rs_ready  = w_run & (r_rs_cnt < DEPTH_C);
    assign w_lsb_ready = w_run & (r_lsb_cnt < DEPTH_C);
    assign w_rs_push   = bus.rs_valid & w_rs_ready & rst_in;
    assign w_lsb_push  = bus.lsb_valid & w_lsb_ready & rst_in;
    assign w_rs_ne     = (r_rs_cnt != '0);
    assign w_lsb_ne    = (r_lsb_cnt != '0);
    assign w_rs_head   = r_rs_mem[r_rs_rp];
    assign w_lsb_head  = r_lsb_mem[r_lsb_rp];

    // Choose at most one FIFO head to broadcast this cycle
    always_comb begin
        w_grant_rs  = 1'b0;
        w_grant_lsb = 1'b0;
        if (w_run) begin
            unique case (1'b1)
                (w_rs_ne & w_lsb_ne): begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
                    w_grant_lsb = r_prio_lsb;
                    w_grant_rs  = ~r_prio_lsb;
`else
                    w_grant_lsb = 1'b1;
`endif
                end
                (w_rs_ne & ~w_lsb_ne): w_grant_rs  = 1'b1;
                (~w_rs_ne & w_lsb_ne): w_grant_lsb = 1'b1;
                default: ;
            endcase
        end
    end

    // RS FIFO storage; pushes only happen out of reset with the bus running
    always_ff @(posedge clk) begin
        if (w_rs_push) begin
            r_rs_mem[r_rs_wp] <= {bus.rs_entry, bus.rs_result};
        end
    end

    // RS FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_rs_wp  <= '0;
            r_rs_rp  <= '0;
            r_rs_cnt <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                r_rs_wp  <= '0;
                r_rs_rp  <= '0;
                r_rs_cnt <= '0;
            end else begin
                if (w_rs_push) begin
                    r_rs_wp <= r_rs_wp + PW'(1);
                end
                if (w_grant_rs) begin
                    r_rs_rp <= r_rs_rp + PW'(1);
                end
                case ({w_rs_push, w_grant_rs})
                    2'b10:   r_rs_cnt <= r_rs_cnt + CW'(1);
                    2'b01:   r_rs_cnt <= r_rs_cnt - CW'(1);
                    default: r_rs_cnt <= r_rs_cnt;
                endcase
            end
        end
    end

    // LSB FIFO storage; pushes only happen out of reset with the bus running
    always_ff @(posedge clk) begin
        if (w_lsb_push) begin
            r_lsb_mem[r_lsb_wp] <= {bus.lsb_entry, bus.lsb_result};
        end
    end

    // LSB FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_lsb_wp  <= '0;
            r_lsb_rp  <= '0;
            r_lsb_cnt <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                r_lsb_wp  <= '0;
                r_lsb_rp  <= '0;
                r_lsb_cnt <= '0;
            end else begin
                if (w_lsb_push) begin
                    r_lsb_wp <= r_lsb_wp + PW'(1);
                end
                if (w_grant_lsb) begin
                    r_lsb_rp <= r_lsb_rp + PW'(1);
                end
                case ({w_lsb_push, w_grant_lsb})
                    2'b10:   r_lsb_cnt <= r_lsb_cnt + CW'(1);
                    2'b01:   r_lsb_cnt <= r_lsb_cnt - CW'(1);
                    default: r_lsb_cnt <= r_lsb_cnt;
                endcase
            end
        end
    end

`ifdef CDB_ARB_ROUND_ROBIN_EN
    // Flip priority only when both sources competed for the bus
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_prio_lsb <= 1'b0;
        end else if (w_grant_rs & w_lsb_ne) begin
            r_prio_lsb <= 1'b1;
        end else if (w_grant_lsb & w_rs_ne) begin
            r_prio_lsb <= 1'b0;
        end
    end
`endif

    // Register the granted head onto the broadcast bus; payload holds when idle
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_entry  <= '0;
            r_cdb_result <= '0;
            r_cdb_src    <= 1'b0;
        end else if (rdy_in) begin
            if (roll_back) begin
                r_cdb_valid <= 1'b0;
            end else if (w_grant_lsb) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_entry  <= w_lsb_head[DW-1:32];
                r_cdb_result <= w_lsb_head[31:0];
                r_cdb_src    <= 1'b1;
            end else if (w_grant_rs) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_entry  <= w_rs_head[DW-1:32];
                r_cdb_result <= w_rs_head[31:0];
                r_cdb_src    <= 1'b0;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign bus.rs_ready   = w_rs_ready;
    assign bus.lsb_ready  = w_lsb_ready;
    assign bus.cdb_valid  = r_cdb_valid;
    assign bus.cdb_entry  = r_cdb_entry;
    assign bus.cdb_result = r_cdb_result;
    assign bus.cdb_src    = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_cdb_arbiter;
    localparam int ES = 4;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic roll_back;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.ENTRY_SIZE(ES)) bus ();

    cdb_arbiter #(
        .ENTRY_SIZE(ES),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .roll_back(roll_back),
        .bus(bus)
    );

    typedef struct packed {
        logic [ES-1:0] e;
        logic [31:0]   r;
    } item_t;

    item_t rq[$];
    item_t lq[$];
    bit    m_prio_lsb;
    bit    m_v;
    logic [ES-1:0] m_e;
    logic [31:0]   m_r;
    bit    m_s;

    int seen[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic idle();
        bus.rs_valid   = 1'b0;
        bus.lsb_valid  = 1'b0;
        bus.rs_entry   = '0;
        bus.lsb_entry  = '0;
        bus.rs_result  = '0;
        bus.lsb_result = '0;
        roll_back      = 1'b0;
        rdy_in         = 1'b1;
    endtask

    task automatic push_rs(int e, int r);
        bus.rs_valid  = 1'b1;
        bus.rs_entry  = ES'(e);
        bus.rs_result = 32'(r);
    endtask

    task automatic push_lsb(int e, int r);
        bus.lsb_valid  = 1'b1;
        bus.lsb_entry  = ES'(e);
        bus.lsb_result = 32'(r);
    endtask

    function automatic bit m_rs_ready();
        return rdy_in && !roll_back && (rq.size() < D);
    endfunction

    function automatic bit m_lsb_ready();
        return rdy_in && !roll_back && (lq.size() < D);
    endfunction

    // One clock: check ready, advance model at the edge, check broadcast.
    task automatic tick();
        bit er, el, rsg, lsg, adv;
        item_t it;
        #1;
        er  = m_rs_ready();
        el  = m_lsb_ready();
        adv = rst_in && rdy_in;
        chk("rs_ready", 64'(bus.rs_ready), 64'(er));
        chk("lsb_ready", 64'(bus.lsb_ready), 64'(el));
        @(posedge clk);
        if (!rst_in) begin
            rq.delete();
            lq.delete();
            m_v = 0; m_e = '0; m_r = '0; m_s = 0;
            m_prio_lsb = 0;
        end else if (rdy_in) begin
            if (roll_back) begin
                rq.delete();
                lq.delete();
                m_v = 0;
            end else begin
                rsg = 0;
                lsg = 0;
                if (rq.size() > 0 && lq.size() > 0) begin
`ifdef CDB_ARB_ROUND_ROBIN_EN
                    lsg = m_prio_lsb;
                    rsg = !m_prio_lsb;
                    m_prio_lsb = rsg;
`else
                    lsg = 1;
`endif
                end else begin
                    rsg = rq.size() > 0;
                    lsg = lq.size() > 0;
                end
                if (lsg) begin
                    it = lq.pop_front();
                    m_v = 1; m_e = it.e; m_r = it.r; m_s = 1;
                end else if (rsg) begin
                    it = rq.pop_front();
                    m_v = 1; m_e = it.e; m_r = it.r; m_s = 0;
                end else begin
                    m_v = 0;
                end
                if (bus.rs_valid && er) rq.push_back({bus.rs_entry, bus.rs_result});
                if (bus.lsb_valid && el) lq.push_back({bus.lsb_entry, bus.lsb_result});
            end
        end
        #1;
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_v));
        chk("cdb_entry", 64'(bus.cdb_entry), 64'(m_e));
        chk("cdb_result", 64'(bus.cdb_result), 64'(m_r));
        chk("cdb_src", 64'(bus.cdb_src), 64'(m_s));
        if (adv && bus.cdb_valid) seen.push_back(int'(bus.cdb_entry));
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        seen.delete();
    endtask

    task automatic chk_seen(string n, int exp[]);
        chk({n, "_count"}, 64'(seen.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk({n, "_order"}, 64'(seen[i]), 64'(exp[i]));
    endtask

    int exp2[];
    int exp5[];
    int lit5;
    int idx;
    int cyc;
    int n_rb;
    bit acc;

    initial begin
        idle();
        rst_in = 1'b0;
        @(negedge clk);
        do_reset();

        // reset state
        #1;
        chk("rst_valid", 64'(bus.cdb_valid), 64'(0));
        chk("rst_entry", 64'(bus.cdb_entry), 64'(0));
        chk("rst_result", 64'(bus.cdb_result), 64'(0));
        chk("rst_src", 64'(bus.cdb_src), 64'(0));
        chk("rst_rs_ready", 64'(bus.rs_ready), 64'(1));
        chk("rst_lsb_ready", 64'(bus.lsb_ready), 64'(1));

        // single RS item: broadcast exactly two edges after acceptance
        push_rs(3, 32'h1234);
        tick();
        idle();
        chk("s1_early_valid", 64'(bus.cdb_valid), 64'(0));
        tick();
        chk("s1_valid", 64'(bus.cdb_valid), 64'(1));
        chk("s1_entry", 64'(bus.cdb_entry), 64'(3));
        chk("s1_result", 64'(bus.cdb_result), 64'(32'h1234));
        chk("s1_src", 64'(bus.cdb_src), 64'(0));
        tick();
        chk("s1_drop_valid", 64'(bus.cdb_valid), 64'(0));
        chk("s1_hold_entry", 64'(bus.cdb_entry), 64'(3));

        // simultaneous push from both sources
        do_reset();
        push_rs(1, 32'h11);
        push_lsb(2, 32'h22);
        tick();
        idle();
        tick();
        tick();
        tick();
`ifdef CDB_ARB_ROUND_ROBIN_EN
        exp2 = '{1, 2};
`else
        exp2 = '{2, 1};
`endif
        chk_seen("s2", exp2);

        // LSB streams four items, RS idle
        do_reset();
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            push_lsb(4 + idx, 32'h400 + idx);
            #1;
            acc = m_lsb_ready();
            tick();
            if (acc) idx++;
            cyc++;
        end
        chk("s3_accepted", 64'(idx), 64'(4));
        idle();
        repeat (4) tick();
        chk_seen("s3", '{4, 5, 6, 7});

        // loaded FIFOs flushed by a one-cycle roll_back
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_rs(8 + k, 32'h800 + k);
            push_lsb(12 + k, 32'hc00 + k);
            tick();
        end
        idle();
        roll_back = 1'b1;
        tick();
        n_rb = seen.size();
        chk("s4_valid_after_rb", 64'(bus.cdb_valid), 64'(0));
        roll_back = 1'b0;
        #1;
        chk("s4_rs_ready", 64'(bus.rs_ready), 64'(1));
        chk("s4_lsb_ready", 64'(bus.lsb_ready), 64'(1));
        repeat (4) tick();
        chk("s4_no_flushed_bcast", 64'(seen.size()), 64'(n_rb));

        // pause with items queued and a live broadcast
        do_reset();
        push_rs(1, 32'h101);
        push_lsb(2, 32'h202);
        tick();
        push_rs(3, 32'h303);
        push_lsb(4, 32'h404);
        tick();
        idle();
`ifdef CDB_ARB_ROUND_ROBIN_EN
        lit5 = 1;
        exp5 = '{1, 2, 3, 4};
`else
        lit5 = 2;
        exp5 = '{2, 4, 1, 3};
`endif
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("s5_pause_rs_ready", 64'(bus.rs_ready), 64'(0));
            chk("s5_pause_lsb_ready", 64'(bus.lsb_ready), 64'(0));
            tick();
            chk("s5_pause_valid", 64'(bus.cdb_valid), 64'(1));
            chk("s5_pause_entry", 64'(bus.cdb_entry), 64'(lit5));
        end
        rdy_in = 1'b1;
        repeat (4) tick();
        chk_seen("s5", exp5);

        // reset in the middle of draining
        do_reset();
        push_rs(5, 32'h505);
        push_lsb(6, 32'h606);
        tick();
        push_rs(7, 32'h707);
        push_lsb(8, 32'h808);
        tick();
        idle();
        chk("s6_live", 64'(bus.cdb_valid), 64'(1));
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        n_rb = seen.size();
        chk("s6_valid", 64'(bus.cdb_valid), 64'(0));
        chk("s6_entry", 64'(bus.cdb_entry), 64'(0));
        chk("s6_result", 64'(bus.cdb_result), 64'(0));
        #1;
        chk("s6_rs_ready", 64'(bus.rs_ready), 64'(1));
        chk("s6_lsb_ready", 64'(bus.lsb_ready), 64'(1));
        repeat (4) tick();
        chk("s6_no_stale", 64'(seen.size()), 64'(n_rb));

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_in         = ($urandom_range(99) != 0);
            rdy_in         = ($urandom_range(9) != 0);
            roll_back      = ($urandom_range(29) == 0);
            bus.rs_valid   = 1'($urandom_range(1));
            bus.lsb_valid  = 1'($urandom_range(1));
            bus.rs_entry   = ES'($urandom);
            bus.lsb_entry  = ES'($urandom);
            bus.rs_result  = $urandom;
            bus.lsb_result = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
